// File: rtl/shared_mem_arbiter_pkg.sv
// Shared encodings for the shared memory arbiter: FSM states, operation codes
// and the index-width helper used to size grant pointers.
package shared_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DONE  = 2'd3
  } arb_state_t;

  localparam logic ARB_OP_READ  = 1'b0;
  localparam logic ARB_OP_WRITE = 1'b1;

  // A single core still needs a 1-bit pointer so port widths never collapse to zero.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_mem_arbiter_rr_picker.sv
// Round-robin winner selection: scans request bits starting one past the
// previous grant, wrapping modulo NUM_CORES.
module shared_mem_arbiter_rr_picker
  import shared_mem_arbiter_pkg::*;
#(
  parameter  int NUM_CORES = 2,
  localparam int IW        = idx_width(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] i_req,
  input  logic [IW-1:0]        i_last_grant,
  output logic                 o_any_req,
  output logic [IW-1:0]        o_winner
);

  always_comb begin
    int idx;
    o_any_req = 1'b0;
    o_winner  = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      idx = (int'(i_last_grant) + k) % NUM_CORES;
      if (!o_any_req && i_req[idx]) begin
        o_any_req = 1'b1;
        o_winner  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Shares one single-port synchronous memory between NUM_CORES cores, serving
// one latched request at a time and returning a one-cycle ack to its owner.
//
//   state | meaning
//   IDLE  | pick next requester round-robin, latch its request
//   ISSUE | drive one memory strobe, or flag an out-of-range address
//   WAIT  | capture read data returned by the memory
//   DONE  | pulse ack to the granted core, advance the pointer
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int MEM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CORES-1:0]            req_valid,
  input  logic [NUM_CORES-1:0]            req_write,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CORES*MEM_WIDTH-1:0]  req_wdata,
  output logic [NUM_CORES-1:0]            resp_ack,
  output logic                            resp_err,
  output logic [MEM_WIDTH-1:0]            resp_rdata,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic                            mem_read_en,
  output logic                            mem_write_en,
  output logic [MEM_WIDTH-1:0]            mem_write_val,
  input  logic [MEM_WIDTH-1:0]            mem_read_val
);

  localparam int                  IW          = idx_width(NUM_CORES);
  localparam logic [IW-1:0]       LP_LAST     = IW'(NUM_CORES - 1);
  localparam logic [ADDR_WIDTH:0] LP_MEM_SIZE = (ADDR_WIDTH + 1)'(MEM_SIZE);

  arb_state_t             r_state;
  arb_state_t             w_next_state;
  logic [IW-1:0]          r_gnt;
  logic [IW-1:0]          r_last_grant;
  logic                   r_write;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [MEM_WIDTH-1:0]   r_wdata;
  logic [MEM_WIDTH-1:0]   r_rdata;
  logic                   r_err;
  logic                   w_any_req;
  logic [IW-1:0]          w_winner;
  logic                   w_out_of_range;

  shared_mem_arbiter_rr_picker #(
    .NUM_CORES(NUM_CORES)
  ) u_picker (
    .i_req       (req_valid),
    .i_last_grant(r_last_grant),
    .o_any_req   (w_any_req),
    .o_winner    (w_winner)
  );

  // Full-width unsigned compare; an extra MSB keeps MEM_SIZE representable.
  assign w_out_of_range = ({1'b0, r_addr} >= LP_MEM_SIZE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= LP_LAST;
      r_gnt        <= '0;
      r_write      <= ARB_OP_READ;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_gnt   <= w_winner;
            r_write <= req_write[w_winner];
            r_addr  <= req_addr[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata <= req_wdata[int'(w_winner)*MEM_WIDTH +: MEM_WIDTH];
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        ARB_ISSUE: r_err        <= w_out_of_range;
        ARB_WAIT:  r_rdata      <= mem_read_val;
        ARB_DONE:  r_last_grant <= r_gnt;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state  = r_state;
    mem_read_en   = 1'b0;
    mem_write_en  = 1'b0;
    mem_addr      = '0;
    mem_write_val = '0;
    resp_ack      = '0;
    resp_err      = 1'b0;
    resp_rdata    = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) w_next_state = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        if (w_out_of_range) begin
          w_next_state = ARB_DONE;
        end else if (r_write == ARB_OP_WRITE) begin
          mem_write_en  = 1'b1;
          mem_addr      = r_addr;
          mem_write_val = r_wdata;
          w_next_state  = ARB_DONE;
        end else begin
          mem_read_en  = 1'b1;
          mem_addr     = r_addr;
          w_next_state = ARB_WAIT;
        end
      end
      ARB_WAIT: w_next_state = ARB_DONE;
      ARB_DONE: begin
        resp_ack     = NUM_CORES'(1) << r_gnt;
        resp_err     = r_err;
        resp_rdata   = r_rdata;
        w_next_state = ARB_IDLE;
      end
      default: w_next_state = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter: cores are modelled as request
// drivers, the memory as a one-cycle-latency array, checks run in a monitor.
module tb_shared_mem_arbiter;

  localparam int NC     = 2;
  localparam int MW     = 32;
  localparam int AW     = 32;
  localparam int MS     = 256;
  localparam int REGION = 64;

  typedef struct {
    int            core;
    logic [MW-1:0] rdata;
    logic          err;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NC-1:0]     req_valid;
  logic [NC-1:0]     req_write;
  logic [NC*AW-1:0]  req_addr;
  logic [NC*MW-1:0]  req_wdata;
  logic [NC-1:0]     resp_ack;
  logic              resp_err;
  logic [MW-1:0]     resp_rdata;
  logic [AW-1:0]     mem_addr;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [MW-1:0]     mem_write_val;
  logic [MW-1:0]     mem_read_val;

  exp_t          exp_q[$];
  int            ack_log[$];
  logic [MW-1:0] mem     [MS];
  logic [MW-1:0] ref_mem [MS];
  bit            mem_init_done = 1'b0;
  int            cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  int            strobe_cnt = 0;
  int            rd_cyc = -1;
  int            wr_cyc = -1;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [MW-1:0] wr_val = '0;
  int            ack_cnt [NC];
  int            ack_cyc [NC];
  int            waits   [NC];
  bit            pending [NC];

  always #5 clk = ~clk;

  shared_mem_arbiter #(
    .NUM_CORES (NC),
    .MEM_WIDTH (MW),
    .ADDR_WIDTH(AW),
    .MEM_SIZE  (MS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_ack     (resp_ack),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_write_val(mem_write_val),
    .mem_read_val (mem_read_val)
  );

  function automatic logic [MW-1:0] init_val(input int i);
    return (i == 5) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | MW'(i));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: read data appears the cycle after the strobe, poison otherwise.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < MS; i++) mem[i] <= init_val(i);
      mem_init_done <= 1'b1;
    end else if (mem_write_en && mem_addr < MS) begin
      mem[mem_addr] <= mem_write_val;
    end
    mem_read_val <= (mem_read_en && mem_addr < MS) ? mem[mem_addr] : 32'hBAD0_0BAD;
  end

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: result is fixed at issue time from a shadow memory.
  task automatic issue(input int c, input logic wr, input logic [AW-1:0] a, input logic [MW-1:0] d);
    exp_t e;
    req_valid[c]             = 1'b1;
    req_write[c]             = wr;
    req_addr[c*AW +: AW]     = a;
    req_wdata[c*MW +: MW]    = d;
    e.core  = c;
    e.err   = (a >= MS);
    e.rdata = '0;
    if (!e.err) begin
      if (wr) ref_mem[a] = d;
      else    e.rdata    = ref_mem[a];
    end
    exp_q.push_back(e);
    pending[c] = 1'b1;
    waits[c]   = 0;
  endtask

  task automatic wait_ack(input int c, input int n0, input bit keep);
    int n;
    n = 0;
    while (ack_cnt[c] == n0 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check(ack_cnt[c] != n0, "ack_timeout", ack_cnt[c] - n0, 1);
    @(posedge clk); #1;
    if (!keep) req_valid[c] = 1'b0;
  endtask

  // Called at posedge+1; lat==0 skips timing checks (contended traffic).
  task automatic run_one(input int c, input logic wr, input logic [AW-1:0] a,
                         input logic [MW-1:0] d, input int lat, input bit keep);
    int k, n0, s0;
    k  = cyc;
    n0 = ack_cnt[c];
    s0 = strobe_cnt;
    issue(c, wr, a, d);
    wait_ack(c, n0, keep);
    if (lat != 0 && ack_cnt[c] != n0) begin
      check(ack_cyc[c] - k == lat, "ack_latency", ack_cyc[c] - k, lat);
      if (a >= MS) begin
        check(strobe_cnt == s0, "err_no_strobe", strobe_cnt - s0, 0);
      end else if (wr) begin
        check(wr_cyc == k + 1, "write_cycle", wr_cyc - k, 1);
        check(wr_addr == a, "write_addr", wr_addr, a);
        check(wr_val == d, "write_data", wr_val, d);
      end else begin
        check(rd_cyc == k + 1, "read_cycle", rd_cyc - k, 1);
        check(rd_addr == a, "read_addr", rd_addr, a);
      end
    end
  endtask

  task automatic rand_core(input int c, input int count);
    for (int t = 0; t < count; t++) begin
      logic          wr;
      logic [AW-1:0] a;
      int            gap;
      wr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       a = AW'(MS + $urandom_range(0, 1000));
        1:       a = {24'hFF_FFFF, 8'($urandom_range(0, 255))};
        default: a = AW'(c * REGION + $urandom_range(0, REGION - 1));
      endcase
      gap = $urandom_range(0, 2);
      run_one(c, wr, a, $urandom, 0, gap == 0);
      repeat (gap) begin @(posedge clk); #1; end
    end
    req_valid[c] = 1'b0;
  endtask

  function automatic bit outs_zero();
    return resp_ack == '0 && !resp_err && resp_rdata == '0 && mem_addr == '0 &&
           !mem_read_en && !mem_write_en && mem_write_val == '0;
  endfunction

  // Monitor: scoreboard pop on every ack plus per-cycle output rules.
  initial begin
    logic [NC-1:0] prev_ack;
    exp_t          e;
    int            g, kk;
    bit            found;
    prev_ack = '0;
    forever begin
      @(negedge clk);
      check(!(mem_read_en && mem_write_en), "strobe_exclusive", {mem_read_en, mem_write_en}, 0);
      if (mem_read_en || mem_write_en) strobe_cnt++;
      if (mem_read_en) begin rd_cyc = cyc; rd_addr = mem_addr; end
      if (mem_write_en) begin wr_cyc = cyc; wr_addr = mem_addr; wr_val = mem_write_val; end
      if (resp_ack == '0) begin
        check(resp_rdata == '0 && !resp_err, "resp_zero_no_ack", {resp_err, resp_rdata}, 0);
      end else begin
        check($onehot(resp_ack), "ack_onehot", resp_ack, 0);
        check((resp_ack & prev_ack) == '0, "ack_single_cycle", resp_ack & prev_ack, 0);
        g = 0;
        for (int i = 0; i < NC; i++) if (resp_ack[i]) g = i;
        found = 1'b0;
        kk    = 0;
        foreach (exp_q[k]) begin
          if (!found && exp_q[k].core == g) begin
            e = exp_q[k]; kk = k; found = 1'b1;
          end
        end
        check(found, "ack_expected", g, 1);
        if (found) begin
          exp_q.delete(kk);
          check(resp_rdata == e.rdata, "resp_rdata", resp_rdata, e.rdata);
          check(resp_err == e.err, "resp_err", resp_err, e.err);
        end
        check(waits[g] <= NC - 1, "fairness_wait", waits[g], NC - 1);
        for (int i = 0; i < NC; i++) if (i != g && pending[i]) waits[i]++;
        pending[g] = 1'b0;
        ack_cnt[g]++;
        ack_cyc[g] = cyc;
        ack_log.push_back(g);
      end
      prev_ack = resp_ack;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int k, n0, m, n;
    reset     = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < MS; i++) ref_mem[i] = init_val(i);
    for (int i = 0; i < NC; i++) begin
      ack_cnt[i] = 0; ack_cyc[i] = -1; waits[i] = 0; pending[i] = 1'b0;
    end

    repeat (3) @(negedge clk);
    check(resp_ack == '0, "reset_ack", resp_ack, 0);
    check(!resp_err, "reset_err", resp_err, 0);
    check(resp_rdata == '0, "reset_rdata", resp_rdata, 0);
    check(!mem_read_en && !mem_write_en, "reset_strobes", {mem_read_en, mem_write_en}, 0);
    check(mem_addr == '0, "reset_mem_addr", mem_addr, 0);
    check(mem_write_val == '0, "reset_mem_wval", mem_write_val, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_one(0, 1'b0, 5, '0, 3, 1'b0);
    run_one(1, 1'b1, 7, 32'h1234_5678, 2, 1'b0);
    run_one(0, 1'b0, 7, '0, 3, 1'b0);
    run_one(0, 1'b0, 256, '0, 2, 1'b0);
    run_one(1, 1'b1, 32'h0000_0105, 32'hCAFE_F00D, 2, 1'b0);
    run_one(1, 1'b0, 32'hFFFF_FFFF, '0, 2, 1'b0);
    run_one(0, 1'b0, 3, '0, 3, 1'b1);
    run_one(0, 1'b1, 4, 32'h0BAD_F00D, 2, 1'b0);
    run_one(0, 1'b0, 4, '0, 3, 1'b0);

    // From reset with both cores hammering: grants must alternate from core 0.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m = ack_log.size();
    fork
      begin
        run_one(0, 1'b0, 10, '0, 0, 1'b1);
        run_one(0, 1'b0, 12, '0, 0, 1'b0);
      end
      begin
        run_one(1, 1'b1, 70, 32'h5555_AAAA, 0, 1'b1);
        run_one(1, 1'b0, 70, '0, 0, 1'b0);
      end
    join
    check(ack_log.size() == m + 4, "rr_ack_count", ack_log.size() - m, 4);
    for (int i = 0; i < 4; i++) begin
      if (m + i < ack_log.size()) check(ack_log[m + i] == i % 2, "rr_order", ack_log[m + i], i % 2);
    end

    // Reset during WAIT of a core 1 read; core 0 also requesting afterwards.
    issue(1, 1'b0, 72, '0);
    k  = cyc;
    n0 = ack_cnt[1];
    @(posedge clk); #1;
    @(posedge clk); #1;
    check(rd_cyc == k + 1, "pre_reset_read_cycle", rd_cyc - k, 1);
    reset = 1'b1;
    issue(0, 1'b0, 11, '0);
    @(posedge clk);
    @(negedge clk);
    check(outs_zero(), "reset_mid_outputs", {resp_ack, mem_read_en, mem_write_en}, 0);
    check(ack_cnt[1] == n0, "reset_mid_no_ack", ack_cnt[1] - n0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m = ack_log.size();
    fork
      wait_ack(0, ack_cnt[0], 1'b0);
      wait_ack(1, n0, 1'b0);
    join
    check(ack_log.size() == m + 2, "post_reset_ack_count", ack_log.size() - m, 2);
    if (ack_log.size() >= m + 2) begin
      check(ack_log[m] == 0, "post_reset_first", ack_log[m], 0);
      check(ack_log[m + 1] == 1, "post_reset_second", ack_log[m + 1], 1);
    end

    fork
      rand_core(0, 80);
      rand_core(1, 80);
    join

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
